unified_buffer_write_control_unit: RTL and testbench
====================================================

# unified_buffer_write_control_unit

Write-side controller for the unified buffer. It accepts finished output rows from the accumulator/activation path over a valid/ready stream and turns each accepted row into one unified buffer write. It generates the tiled write addresses in the same layout the read-side control unit walks: column-tile major, row within tile minor. It signals completion so the sequencer can issue the next instruction.

## Interface

Parameters:

- `DATA_W`, 256, width of one output row (32 lanes x 8 bit).
- `ADDR_W`, 12, unified buffer address width.

Ports:

- `clk_i`  input  1  clock; all logic on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `start_i`  input  1  one-cycle pulse; starts a write-back job (honoured only in IDLE).
- `unified_buffer_start_addr_wr_i`  input  ADDR_W  base write address; sampled on accepted start.
- `ROWS_dim1_i`  input  7  output rows minus 1 (0..127); sampled on start.
- `COLS_dim1_i`  input  7  output columns minus 1; the number of column tiles is `(COLS_dim1_i>>5)+1`; sampled on start.
- `acc_valid_i`  input  1  output row available.
- `acc_data_i`  input  DATA_W  output row data.
- `acc_ready_o`  output  1  block can accept a row.
- `unified_buffer_write_en_o`  output  1  write strobe.
- `unified_buffer_addr_wr_o`  output  ADDR_W  write address.
- `unified_buffer_data_o`  output  DATA_W  write data.
- `busy_o`  output  1  job in progress.
- `done_o`  output  1  one-cycle pulse: final write issued.

## Operation

- **States:** IDLE, WRITE.
- **IDLE → WRITE:** on `start_i`. In the same edge the block latches:
  - base address, `ROWS_dim1_i`, and tile count;
  - row counter = 0, tile counter = 0;
  - `ROW_STRIDE = ((ROWS_dim1_i>>5)+1)<<5`, ADDR_W bits.
- **WRITE:** `acc_ready_o = 1` and `busy_o = 1` (both combinational from state). A beat is accepted when `acc_valid_i & acc_ready_o`.
- **Address of an accepted beat:** `base + tile*ROW_STRIDE + row`, computed modulo 2^ADDR_W, so it wraps silently past 0xFFF.
- **Counter update per accepted beat:**
  - If `row == latched ROWS_dim1`: row → 0 and tile → tile+1.
  - Otherwise: row → row+1.
- **Last beat** (final row of the final tile): the block returns to IDLE on the same edge.
- **Gaps:** no beat accepted (`acc_valid_i = 0`) → no write, counters hold.
- **Start while busy:** `start_i` in WRITE is ignored. Inputs are not re-sampled and the counters are unaffected.
- **Unsized inputs during a job:** `ROWS_dim1_i` and `COLS_dim1_i` changing mid-job have no effect; only the latched copies are used.
- **Reset in any state:** state → IDLE, counters → 0, all outputs → reset values. A partially written job is abandoned; no `done_o` is produced.

## Timing

- **Reset values:**
  - `acc_ready_o = 0`, `busy_o = 0`, `done_o = 0`;
  - `unified_buffer_write_en_o = 0`;
  - `unified_buffer_addr_wr_o = 0`, `unified_buffer_data_o = 0`.
- **Write latency:** the write strobe is registered and follows acceptance by 1 cycle. On an accept at edge N, the outputs are valid in cycle N+1:
  - `unified_buffer_write_en_o = 1`;
  - address = address of that beat;
  - data = `acc_data_i` of that beat.
- **No accept at edge N:** `unified_buffer_write_en_o = 0` in cycle N+1. Address and data hold their last values.
- **Throughput:** one row per cycle sustained, no bubbles at row or tile boundaries.
- **done_o:** asserted in the same cycle as the final `unified_buffer_write_en_o`, for exactly 1 cycle.
- **busy_o and acc_ready_o at the last beat:** both are already 0 in that cycle, because the state returned to IDLE at the last accept.
- **Start to first accept:** a start at edge S allows the first accept at edge S+1 at the earliest. The first write appears in cycle S+2.
- **Back-to-back jobs:** a new `start_i` is honoured in the cycle `done_o` is high. That cycle is IDLE.
- **Job length:** total writes = `(ROWS_dim1+1) * ((COLS_dim1>>5)+1)`.

## Test plan

- **Single tile:** reset, start, base=0x100, ROWS_dim1=31, COLS_dim1=31, valid held high → 32 writes to 0x100..0x11F on consecutive cycles, data echoed. `done_o` coincides with the write to 0x11F; `busy_o` falls.
- **Padded stride:** base=0x100, ROWS_dim1=40, COLS_dim1=63 → stride 64 and 82 writes: 0x100..0x128, then 0x140..0x168, then `done_o`.
- **Backpressure gaps:** same job as the single-tile case, with `acc_valid_i` toggling 1,0,1,0 → writes only on cycles after accepted beats. Addresses contiguous with no skips; still exactly 32 writes.
- **Wrap-around:** base=0xFF0, ROWS_dim1=31, COLS_dim1=31 → addresses 0xFF0..0xFFF, then 0x000..0x00F.
- **Ignored start:** `start_i` pulsed mid-job with different dims/base → no restart; the original address sequence and count complete. A start in the `done_o` cycle launches the next job, whose first write lands 2 cycles later.
- **Reset mid-job:** `rst_i` after 10 accepts → next cycle all outputs 0, IDLE, no `done_o`. A fresh start then writes from the new base with row/tile = 0.

Source files
------------

// File: rtl/unified_buffer_write_control_unit_if.sv
// Stream and write bus of the unified buffer write control unit.
//   acc_valid_i / acc_data_i / acc_ready_o : accumulator output-row stream
//   unified_buffer_write_en_o / _addr_wr_o / _data_o : unified buffer write port
// Signal suffixes are from the control unit's point of view.
// slave  : the write control unit
// master : the environment (row producer and buffer side)
interface unified_buffer_write_control_unit_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12
);
  logic              acc_valid_i;
  logic [DATA_W-1:0] acc_data_i;
  logic              acc_ready_o;
  logic              unified_buffer_write_en_o;
  logic [ADDR_W-1:0] unified_buffer_addr_wr_o;
  logic [DATA_W-1:0] unified_buffer_data_o;

  modport slave (
    input  acc_valid_i, acc_data_i,
    output acc_ready_o, unified_buffer_write_en_o,
           unified_buffer_addr_wr_o, unified_buffer_data_o
  );

  modport master (
    output acc_valid_i, acc_data_i,
    input  acc_ready_o, unified_buffer_write_en_o,
           unified_buffer_addr_wr_o, unified_buffer_data_o
  );
endinterface

// File: rtl/unified_buffer_write_control_unit.sv
// Write-side controller for the unified buffer. Each accepted output row is
// written to the buffer one cycle later at a tiled address: column-tile
// major, row-within-tile minor, tile stride = rows rounded up to 32.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i                       job start pulse (honoured in IDLE only)
//   unified_buffer_start_addr_wr_i base write address
//   ROWS_dim1_i, COLS_dim1_i      output rows-1 / columns-1
//   busy_o                        job in progress
//   done_o                        one-cycle pulse with the final write
//   ub_if                         row stream in, buffer write port out
module unified_buffer_write_control_unit #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] unified_buffer_start_addr_wr_i,
  input  logic [6:0]        ROWS_dim1_i,
  input  logic [6:0]        COLS_dim1_i,
  output logic              busy_o,
  output logic              done_o,
  unified_buffer_write_control_unit_if.slave ub_if
);

  typedef enum logic [0:0] {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        rows_q, rows_d;
  logic [1:0]        tile_last_q, tile_last_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [6:0]        row_q, row_d;
  logic [1:0]        tile_q, tile_d;
  logic [ADDR_W-1:0] tile_off_q, tile_off_d;   // running tile*stride
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;

  logic              accept;
  logic              row_last;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] stride_new;
  logic              unused_cols;

  // Only the tile index bits of the column count matter.
  assign unused_cols = ^COLS_dim1_i[4:0];

  // Stride is the row count padded up to a multiple of 32.
  assign stride_new = ADDR_W'({5'b0, ROWS_dim1_i[6:5]} + 7'd1) << 5;

  assign accept    = ub_if.acc_valid_i && (state_q == WRITE);
  assign row_last  = (row_q == rows_q);
  assign last_beat = accept && row_last && (tile_q == tile_last_q);
  assign beat_addr = base_q + tile_off_q + ADDR_W'(row_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rows_d      = rows_q;
    tile_last_d = tile_last_q;
    stride_d    = stride_q;
    row_d       = row_q;
    tile_d      = tile_q;
    tile_off_d  = tile_off_q;
    wr_en_d     = accept;
    addr_d      = accept ? beat_addr : addr_q;
    data_d      = accept ? ub_if.acc_data_i : data_q;
    done_d      = last_beat;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = WRITE;
          base_d      = unified_buffer_start_addr_wr_i;
          rows_d      = ROWS_dim1_i;
          tile_last_d = COLS_dim1_i[6:5];
          stride_d    = stride_new;
          row_d       = 7'd0;
          tile_d      = 2'd0;
          tile_off_d  = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          if (row_last) begin
            row_d      = 7'd0;
            tile_d     = tile_q + 2'd1;
            tile_off_d = tile_off_q + stride_q;
          end else begin
            row_d = row_q + 7'd1;
          end
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      rows_q      <= '0;
      tile_last_q <= '0;
      stride_q    <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      tile_off_q  <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      tile_last_q <= tile_last_d;
      stride_q    <= stride_d;
      row_q       <= row_d;
      tile_q      <= tile_d;
      tile_off_q  <= tile_off_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign ub_if.acc_ready_o               = (state_q == WRITE);
  assign busy_o                          = (state_q == WRITE);
  assign done_o                          = done_q;
  assign ub_if.unified_buffer_write_en_o = wr_en_q;
  assign ub_if.unified_buffer_addr_wr_o  = addr_q;
  assign ub_if.unified_buffer_data_o     = data_q;

endmodule

// File: tb/tb_unified_buffer_write_control_unit.sv
module tb_unified_buffer_write_control_unit;
  localparam int DW = 256;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_in;
  logic [6:0]    rows_in;
  logic [6:0]    cols_in;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  unified_buffer_write_control_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  unified_buffer_write_control_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i                          (clk),
    .rst_i                          (rst),
    .start_i                        (start),
    .unified_buffer_start_addr_wr_i (base_in),
    .ROWS_dim1_i                    (rows_in),
    .COLS_dim1_i                    (cols_in),
    .busy_o                         (busy),
    .done_o                         (done),
    .ub_if                          (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
    bit            first;
    time           ts;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  bit  m_busy = 1'b0;
  int  m_base, m_rows, m_tl, m_stride, m_row, m_tile;
  time m_ts;
  bit  m_first;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_job(input int b, input int r, input int c);
    @(negedge clk);
    base_in = AW'(b);
    rows_in = 7'(r);
    cols_in = 7'(c);
    start   = 1'b1;
    bus.acc_valid_i = 1'b0;
    @(posedge clk);
    m_base   = b;
    m_rows   = r;
    m_tl     = c >> 5;
    m_stride = ((r >> 5) + 1) * 32;
    m_row    = 0;
    m_tile   = 0;
    m_busy   = 1'b1;
    m_ts     = $time;
    m_first  = 1'b1;
  endtask

  // mode 0: valid held high; mode 1: valid toggles 1,0,1,0
  task automatic feed(input int mode, input int stop_after, input bit inject);
    int   beat = 0;
    int   cyc = 0;
    bit   v;
    bit   injected = 1'b0;
    exp_t e;
    logic [DW-1:0] d;
    while (m_busy && beat != stop_after && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && !injected && beat == 5) begin
        start    = 1'b1;
        base_in  = 12'h800;
        rows_in  = 7'd5;
        cols_in  = 7'd100;
        injected = 1'b1;
      end
      v = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      bus.acc_valid_i = v;
      bus.acc_data_i  = d;
      @(posedge clk);
      cyc++;
      if (v) begin
        e.addr  = AW'(m_base + m_tile * m_stride + m_row);
        e.data  = d;
        e.first = m_first;
        e.ts    = m_ts;
        e.last  = (m_row == m_rows) && (m_tile == m_tl);
        sb.push_back(e);
        pushed++;
        m_first = 1'b0;
        beat++;
        if (m_row == m_rows) begin
          m_row = 0;
          m_tile++;
        end else begin
          m_row++;
        end
        if (e.last) m_busy = 1'b0;
      end
    end
    if (cyc >= 2000) chk("feed_timeout", 1, 0);
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    bus.acc_valid_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("ready", bus.acc_ready_o, m_busy);
      chk("busy", busy, m_busy);
      if (bus.unified_buffer_write_en_o) begin
        if (sb.size() == 0) begin
          chk("spurious_wr", 1, 0);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("addr", bus.unified_buffer_addr_wr_o, e.addr);
          chk("data", bus.unified_buffer_data_o, e.data);
          chk("done", done, e.last);
          if (e.first) chk("first_lat", $time - e.ts, 15);
        end
      end else if (done) begin
        chk("done_nowr", done, 0);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wen"},   bus.unified_buffer_write_en_o, 0);
    chk({tag, "_addr"},  bus.unified_buffer_addr_wr_o, 0);
    chk({tag, "_data"},  bus.unified_buffer_data_o, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ready"}, bus.acc_ready_o, 0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    start = 1'b0;
    base_in = '0;
    rows_in = '0;
    cols_in = '0;
    bus.acc_valid_i = 1'b0;
    bus.acc_data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst");
    rst = 1'b0;
    mon_en = 1'b1;

    // Single tile
    p0 = popped;
    start_job(12'h100, 31, 31);
    feed(0, -1, 1'b0);
    drain();
    chk("n_single", popped - p0, 32);

    // Padded stride: 41 rows x 2 tiles
    p0 = popped;
    start_job(12'h100, 40, 63);
    feed(0, -1, 1'b0);
    drain();
    chk("n_padded", popped - p0, 82);

    // Valid gaps
    p0 = popped;
    start_job(12'h100, 31, 31);
    feed(1, -1, 1'b0);
    drain();
    chk("n_gaps", popped - p0, 32);

    // Address wrap-around
    p0 = popped;
    start_job(12'hFF0, 31, 31);
    feed(0, -1, 1'b0);
    drain();
    chk("n_wrap", popped - p0, 32);

    // Ignored mid-job start, then back-to-back start in the done cycle
    p0 = popped;
    start_job(12'h300, 31, 31);
    feed(0, -1, 1'b1);
    start_job(12'h400, 3, 0);
    feed(0, -1, 1'b0);
    drain();
    chk("n_b2b", popped - p0, 36);

    // Reset after 10 accepts, then a fresh job
    p0 = popped;
    start_job(12'h200, 31, 63);
    feed(0, 10, 1'b0);
    @(negedge clk);
    bus.acc_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    m_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("midrst");
    chk("sb_after_rst", sb.size(), 0);
    chk("n_before_rst", popped - p0, 10);
    p0 = popped;
    start_job(12'h500, 31, 31);
    feed(0, -1, 1'b0);
    drain();
    chk("n_after_rst", popped - p0, 32);

    chk("sb_empty", sb.size(), 0);
    chk("all_written", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
